// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
//
// Purpose:
//   Adds or subtracts two W-bit operands (W = 4*NIBBLES) by feeding one
//   shared 4-bit ripple-carry adder one nibble per clock, LSB nibble first.
//   The carry between nibbles is held in a register. Operations come in over
//   a valid/ready handshake and results leave over a second one. It is used
//   for wide credit/price arithmetic in the vending datapath.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  op_a/op_b/sub valid this cycle
//   in_ready   out  1  ready to accept an operation (IDLE only)
//   op_a       in   W  operand A
//   op_b       in   W  operand B
//   sub        in   1  0: A+B, 1: A-B
//   busy       out  1  sequencing nibbles (RUN)
//   out_valid  out  1  result/flags valid (DONE only)
//   out_ready  in   1  consumer takes the result
//   result     out  W  A+B or A-B modulo 2^W
//   carry_out  out  1  raw carry out of the top nibble (sub: 1 = no borrow)
//   overflow   out  1  two's-complement signed overflow
// ---------------------------------------------------------------------------

// 4-bit ripple-carry adder shared across all nibbles of an operation.
module ex38_rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = c[4];

endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 sub,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry_out,
  output logic                 overflow
);

  localparam int W     = 4 * NIBBLES;
  // Keep the index at least one bit wide so NIBBLES=1 still elaborates.
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q,     state_d;
  logic [W-1:0]     a_q,         a_d;
  logic [W-1:0]     b_q,         b_d;
  logic [W-1:0]     result_q,    result_d;
  logic             carry_q,     carry_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q,  overflow_d;

  // Current nibble presented to the shared adder.
  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [3:0] nib_sum;
  logic       nib_cout;

  assign nib_a = a_q[4*idx_q +: 4];
  assign nib_b = b_q[4*idx_q +: 4];

  ex38_rca4 u_adder (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1: invert B once here and seed the carry.
          a_d     = op_a;
          b_d     = op_b ^ {W{sub}};
          carry_d = sub;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        result_d[4*idx_q +: 4] = nib_sum;
        carry_d                = nib_cout;
        idx_d                  = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          carry_out_d = nib_cout;
          // Signed overflow: operands (B after inversion) agree in sign
          // but the top sum bit disagrees with them.
          overflow_d  = (a_q[W-1] == b_q[W-1]) && (nib_sum[3] != a_q[W-1]);
          idx_d       = '0;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
module tb_nibble_serial_adder_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: plain W+1-bit arithmetic on the whole word.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] bb;
    logic [W:0]   full;
    exp_t         e;
    bb    = s ? ~b : b;
    full  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
    e.res = full[W-1:0];
    e.c   = full[W];
    e.v   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return e;
  endfunction

  // Drive one operation, check latency and results, optionally hold off
  // the drain for hold_cycles while probing that new input is ignored.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input int hold_cycles);
    exp_t e;
    int   lat;
    logic got;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    sub      = s;
    sb.push_back(model(a, b, s));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble operands: they must not matter after the accept edge.
    op_a     = W'($urandom);
    op_b     = W'($urandom);
    sub      = ~s;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) chk("busy_run", busy, 1);
      got = out_valid;
    end
    chk("latency", lat, NIBBLES);
    e = sb.pop_front();
    chk("result", result, e.res);
    chk("carry_out", carry_out, e.c);
    chk("overflow", overflow, e.v);
    $display("[TB] op a=0x%04h b=0x%04h sub=%0d -> result=0x%04h c=%0d v=%0d (exp 0x%04h %0d %0d) lat=%0d",
             a, b, s, result, carry_out, overflow, e.res, e.c, e.v, lat);
    for (int i = 0; i < hold_cycles; i++) begin
      if (i == 3) begin
        in_valid = 1'b1;
        op_a     = 16'hAAAA;
        op_b     = 16'h5555;
        sub      = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end else begin
        @(posedge clk);
      end
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_busy", busy, 0);
      chk("hold_result", result, e.res);
      chk("hold_carry", carry_out, e.c);
      chk("hold_ovf", overflow, e.v);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("drain_in_ready", in_ready, 1);
    chk("drain_out_valid", out_valid, 0);
    chk("drain_result_kept", result, e.res);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    sub       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;

    do_op(16'h1234, 16'h0FCC, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 0);
    do_op(16'h0005, 16'h0007, 1'b1, 0);
    do_op(16'h0007, 16'h0005, 1'b1, 0);
    do_op(16'h8000, 16'h0001, 1'b1, 0);
    do_op(16'h4321, 16'h1111, 1'b0, 10);

    // Reset in the middle of RUN, once idx has reached 2.
    @(negedge clk);
    in_valid = 1'b1;
    op_a     = 16'h1111;
    op_b     = 16'h2222;
    sub      = 1'b0;
    sb.push_back(model(16'h1111, 16'h2222, 1'b0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    $display("[TB] reset mid-op: in_ready=%0d busy=%0d out_valid=%0d result=0x%04h",
             in_ready, busy, out_valid, result);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h0001, 16'h0001, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
